// File: rtl/sha256_wsched_ctrl.sv
// SHA-256 message schedule generator: loads M[0..15], then streams W[0..63] with ready/valid.
// Optional abort input is compiled in when SHA256_WSCHED_ABORT_EN is defined.
module sha256_wsched_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
`ifdef SHA256_WSCHED_ABORT_EN
   input  logic        abort,
`endif
   input  logic [31:0] msg_in,
   input  logic        msg_valid,
   output logic        msg_ready,
   output logic [31:0] wt,
   output logic        wt_valid,
   input  logic        wt_ready,
   output logic [5:0]  t_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [15:0][31:0] window_reg, window_next;
   logic [3:0]        k_reg, k_next;
   logic [5:0]        t_reg, t_next;
   logic              abort_hit;
   logic              load_fire;
   logic              xfer;
   logic              w_new_en;
   logic [31:0]       w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

`ifdef SHA256_WSCHED_ABORT_EN
   assign abort_hit = abort && ((state_reg == LOAD) || (state_reg == EMIT));
`else
   assign abort_hit = 1'b0;
`endif

   // Abort wins over a simultaneous load or transfer.
   assign load_fire = (state_reg == LOAD) && msg_valid && !abort_hit;
   assign xfer      = (state_reg == EMIT) && wt_ready && !abort_hit;

   // Only W[16..63] are ever needed; past t=47 the top entry just fills with zero.
   assign w_new_en = (t_reg <= 6'd47);
   assign w_new    = window_reg[0] + sig0(window_reg[1]) + window_reg[9] + sig1(window_reg[14]);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_win
         logic [31:0] shift_in;
         if (gi < 15) begin : g_mid
            assign shift_in = window_reg[gi+1];
         end else begin : g_top
            assign shift_in = w_new_en ? w_new : 32'h0;
         end
         assign window_next[gi] = (load_fire && (k_reg == 4'(gi))) ? msg_in :
                                  xfer                             ? shift_in :
                                                                     window_reg[gi];
      end
   endgenerate

   always_comb begin
      k_next = k_reg;
      if (state_reg == IDLE || abort_hit) begin
         k_next = 4'd0;
      end else if (load_fire) begin
         k_next = k_reg + 4'd1;
      end
   end

   // t saturates at 63 inside EMIT; it is cleared once the block leaves EMIT.
   always_comb begin
      t_next = t_reg;
      if (state_reg != EMIT || abort_hit) begin
         t_next = 6'd0;
      end else if (xfer && (t_reg != 6'd63)) begin
         t_next = t_reg + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         window_reg <= '0;
         k_reg      <= 4'd0;
         t_reg      <= 6'd0;
      end else begin
         state_reg  <= state_next;
         window_reg <= window_next;
         k_reg      <= k_next;
         t_reg      <= t_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            if (abort_hit) begin
               state_next = IDLE;
            end else if (load_fire && (k_reg == 4'd15)) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (abort_hit) begin
               state_next = IDLE;
            end else if (xfer && (t_reg == 6'd63)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      msg_ready = 1'b0;
      wt_valid  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_reg)
         IDLE:    busy      = 1'b0;
         LOAD:    msg_ready = 1'b1;
         EMIT:    wt_valid  = 1'b1;
         DONE:    done      = 1'b1;
         default: busy      = 1'b0;
      endcase
      wt    = wt_valid ? window_reg[0] : 32'h0;
      t_out = wt_valid ? t_reg : 6'd0;
   end

endmodule

// File: tb/tb_sha256_wsched_ctrl.sv
// Self-checking bench for sha256_wsched_ctrl: directed "abc" cases plus random blocks
// checked against a plain-arithmetic SHA-256 schedule model.
module tb_sha256_wsched_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] msg_in;
   logic        msg_valid;
   logic        msg_ready;
   logic [31:0] wt;
   logic        wt_valid;
   logic        wt_ready;
   logic [5:0]  t_out;
   logic        busy;
   logic        done;
`ifdef SHA256_WSCHED_ABORT_EN
   logic        abort;
`endif

   always #5 clk = ~clk;

   sha256_wsched_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
`ifdef SHA256_WSCHED_ABORT_EN
      .abort     (abort),
`endif
      .msg_in    (msg_in),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .wt        (wt),
      .wt_valid  (wt_valid),
      .wt_ready  (wt_ready),
      .t_out     (t_out),
      .busy      (busy),
      .done      (done)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          emit_cycles;
   logic [31:0] msg  [16];
   logic [31:0] wref [64];
   logic [31:0] got  [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook form: W[i] = s1(W[i-2]) + W[i-7] + s0(W[i-15]) + W[i-16]
   function automatic void build_ref();
      logic [31:0] s0;
      logic [31:0] s1;
      for (int i = 0; i < 16; i++) wref[i] = msg[i];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(wref[i-15], 7) ^ rotr(wref[i-15], 18) ^ (wref[i-15] >> 3);
         s1 = rotr(wref[i-2], 17) ^ rotr(wref[i-2], 19) ^ (wref[i-2] >> 10);
         wref[i] = wref[i-16] + s0 + wref[i-7] + s1;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      build_ref();
   endtask

   task automatic set_random();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      build_ref();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy after start", 32'(busy), 32'd1);
   endtask

   task automatic do_load(input int gap_after, input int gap_len);
      for (int i = 0; i < 16; i++) begin
         msg_valid = 1'b1;
         msg_in    = msg[i];
         check($sformatf("msg_ready k=%0d", i), 32'(msg_ready), 32'd1);
         tick();
         if (i == gap_after) begin
            msg_valid = 1'b0;
            msg_in    = 32'hDEADBEEF;
            for (int g = 0; g < gap_len; g++) begin
               check("msg_ready in gap", 32'(msg_ready), 32'd1);
               check("wt_valid in gap", 32'(wt_valid), 32'd0);
               tick();
            end
         end
      end
      msg_valid = 1'b0;
      msg_in    = 32'h0;
   endtask

   // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: random ready
   task automatic do_emit(input int mode, input int stop_at);
      int idx = 0;
      int cyc = 0;
      bit rdy;
      while (idx < 64 && cyc < 1000) begin
         if (stop_at >= 0 && idx == stop_at) return;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         wt_ready = rdy;
         check($sformatf("wt_valid t=%0d", idx), 32'(wt_valid), 32'd1);
         check($sformatf("t_out t=%0d", idx), 32'(t_out), 32'(idx));
         check($sformatf("wt t=%0d", idx), wt, wref[idx]);
         got[idx] = wt;
         if (rdy) idx++;
         cyc++;
         tick();
      end
      wt_ready    = 1'b0;
      emit_cycles = cyc;
      check("emit transfer count", 32'(idx), 32'd64);
   endtask

   task automatic do_done();
      check("done pulse", 32'(done), 32'd1);
      check("wt_valid in DONE", 32'(wt_valid), 32'd0);
      check("busy in DONE", 32'(busy), 32'd1);
      tick();
      check("done one cycle", 32'(done), 32'd0);
      check("busy back to IDLE", 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " wt_valid"}, 32'(wt_valid), 32'd0);
      check({tag, " msg_ready"}, 32'(msg_ready), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " wt"}, wt, 32'd0);
      check({tag, " t_out"}, 32'(t_out), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      msg_in    = 32'h0;
      msg_valid = 1'b0;
      wt_ready  = 1'b0;
`ifdef SHA256_WSCHED_ABORT_EN
      abort     = 1'b0;
`endif
      #12;
      check_all_zero("reset");
      #8 reset_n = 1'b1;
      tick();
      tick();
      check("idle busy", 32'(busy), 32'd0);

      // "abc" block, consumer always ready
      set_abc();
      do_start();
      do_load(-1, 0);
      do_emit(0, -1);
      check("cycles with ready=1", 32'(emit_cycles), 32'd64);
      check("abc W16", got[16], 32'h61626380);
      check("abc W17", got[17], 32'h000F0000);
      check("abc W18", got[18], 32'h7DA86405);
      check("abc W63", got[63], 32'h12B1EDEB);
      do_done();

      // same block with ready toggling 1,0,0,1
      do_start();
      do_load(-1, 0);
      do_emit(1, -1);
      check("toggle W63", got[63], 32'h12B1EDEB);
      do_done();

      // msg_valid gap of 3 cycles after M[7]
      do_start();
      do_load(7, 3);
      do_emit(0, -1);
      check("gap W63", got[63], 32'h12B1EDEB);
      do_done();

      // asynchronous reset in the middle of emission
      do_start();
      do_load(-1, 0);
      do_emit(0, 30);
      check("t_out before reset", 32'(t_out), 32'd30);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid-emit reset");
      #3 reset_n = 1'b1;
      wt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no emit after reset", 32'(wt_valid), 32'd0);
         check("idle after reset", 32'(busy), 32'd0);
      end
      wt_ready = 1'b0;
      do_start();
      do_load(-1, 0);
      do_emit(0, -1);
      check("post-reset W16", got[16], 32'h61626380);
      do_done();

      // start held through EMIT and DONE
      set_random();
      do_start();
      do_load(-1, 0);
      start = 1'b1;
      do_emit(2, -1);
      do_done();
      check("IDLE with start held", 32'(msg_ready), 32'd0);
      tick();
      check("start sampled in IDLE", 32'(msg_ready), 32'd1);
      start = 1'b0;
      set_random();
      do_load(-1, 0);
      do_emit(2, -1);
      do_done();

      // random blocks with random gaps and backpressure
      for (int b = 0; b < 4; b++) begin
         set_random();
         do_start();
         do_load($urandom_range(0, 14), $urandom_range(0, 4));
         do_emit(2, -1);
         do_done();
      end

`ifdef SHA256_WSCHED_ABORT_EN
      // abort at t=20 together with wt_ready
      set_abc();
      do_start();
      do_load(-1, 0);
      do_emit(0, 20);
      abort    = 1'b1;
      wt_ready = 1'b1;
      check("abort t_out", 32'(t_out), 32'd20);
      check("abort wt", wt, wref[20]);
      tick();
      abort    = 1'b0;
      wt_ready = 1'b0;
      check_all_zero("after abort");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no done after abort", 32'(done), 32'd0);
         check("idle after abort", 32'(busy), 32'd0);
      end
      set_random();
      do_start();
      do_load(-1, 0);
      do_emit(0, -1);
      do_done();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sha256_wsched_ctrl.md
SHA256_WSCHED_CTRL -- requirements
Module: sha256_wsched_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: begins a block; sampled only in IDLE.
REQ-004 SHALL have port msg_in, input, 32 bits: message word M[i], sent in order i=0..15.
REQ-005 SHALL have port msg_valid, input, 1 bit: msg_in is valid.
REQ-006 SHALL have port msg_ready, output, 1 bit: high only in LOAD.
REQ-007 SHALL have port wt, output, 32 bits: schedule word W[t].
REQ-008 SHALL have port wt_valid, output, 1 bit: wt and t_out are valid.
REQ-009 SHALL have port wt_ready, input, 1 bit: the consumer accepts wt.
REQ-010 SHALL have port t_out, output, 6 bits: the index t of the presented wt.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after W[63] is accepted.

Function
REQ-013 SHALL implement the states IDLE, LOAD, EMIT and DONE.
REQ-014 SHALL move IDLE->LOAD when start=1; start SHALL be ignored outside IDLE.
REQ-015 SHALL, in LOAD, accept a word when msg_valid && msg_ready, storing it in window entry k (k=0..15).
REQ-016 SHALL move LOAD->EMIT in the cycle after the 16th word is accepted; wt_valid=1 and wt=M[0] on that cycle.
REQ-017 SHALL maintain a 16-entry window holding W[t..t+15]; wt = window[0] and t_out = t.
REQ-018 SHALL, on each transfer (wt_valid && wt_ready), shift the window down by one and advance t by 1.
REQ-019 SHALL load window[15] on that transfer with W[t+16] = W[t] + s0(W[t+1]) + W[t+9] + s1(W[t+14]), all sums mod 2^32; this applies only while t+16 <= 63.
REQ-020 SHALL compute s0(x) as ror(x,7) ^ ror(x,18) ^ (x>>3).
REQ-021 SHALL compute s1(x) as ror(x,17) ^ ror(x,19) ^ (x>>10).
REQ-022 SHALL hold wt, t_out and wt_valid stable while wt_valid=1 and wt_ready=0 (backpressure); the window SHALL not shift during backpressure.
REQ-023 SHALL, when wt_ready=1 continuously, produce one word per cycle: 64 consecutive cycles for t=0..63.
REQ-024 SHALL move EMIT->DONE on the transfer with t=63; t SHALL not wrap to 0 inside EMIT.
REQ-025 SHALL drive done=1 for exactly one cycle in DONE, then return to IDLE; a start asserted during DONE SHALL be ignored.
REQ-026 SHALL keep wt_valid=0 in IDLE, LOAD and DONE, and msg_ready=0 in every state other than LOAD.
REQ-027 SHALL insert no bubble cycles when msg_valid gaps occur in LOAD; acceptance resumes when msg_valid returns.

Reset
REQ-028 SHALL, while reset_n=0, immediately force state=IDLE, t=0, k=0, window entries=0, wt_valid=0, msg_ready=0, busy=0, done=0, wt=0 and t_out=0.
REQ-029 SHALL, on reset mid-LOAD or mid-EMIT, discard the partial block; after reset release, nothing is emitted until a new start.

Configuration
REQ-030 SHALL, with macro SHA256_WSCHED_ABORT_EN defined, add input port abort (1 bit); abort=1 in LOAD or EMIT SHALL return the block to IDLE on the next edge with wt_valid=0 and done=0, and abort SHALL have priority over a simultaneous transfer.
REQ-031 SHALL, without SHA256_WSCHED_ABORT_EN, have no abort port; a block is always completed or ended only by reset.

Verification
REQ-032 Bench SHALL cover: "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), wt_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; done pulses one cycle after t=63.
REQ-033 Bench SHALL cover: the same block with wt_ready toggling 1,0,0,1 -> identical W sequence, wt and t_out stable during stalls, 64 transfers total.
REQ-034 Bench SHALL cover: msg_valid low for 3 cycles after M[7] -> msg_ready stays 1, M[8..15] stored correctly, same W63.
REQ-035 Bench SHALL cover: reset_n pulsed low at t=30 -> outputs zero immediately; a following start with the "abc" block gives W16=0x61626380.
REQ-036 Bench SHALL cover: start held high during EMIT and DONE -> no effect; returns to IDLE, and a new block begins only when start is sampled in IDLE.
REQ-037 Bench SHALL cover, with SHA256_WSCHED_ABORT_EN defined: abort at t=20 coincident with wt_ready=1 -> no transfer, IDLE next cycle, done never asserted.
